fabric_program_loader: RTL and testbench

Sequencer that sits directly upstream of `fabric`. It accepts a stream of program beats (cell headers and instruction words) and writes each instruction into the addressed cell through the per-row `instr_*` bus. It then pulses `call` on every row and waits for all `ret` lines, reporting completion and the execution cycle count. It replaces the hand-driven load/call/wait sequence with synthesizable control.

---
 rtl/fabric_pkg.sv | 31 +++
 rtl/fabric_program_loader_if.sv | 28 ++
 rtl/fabric_program_writer.sv | 108 ++++++++++
 rtl/fabric_program_loader.sv | 169 ++++++++++++++++
 tb/tb_fabric_program_loader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_pkg.sv
// rtl/fabric_pkg.sv - shared fabric geometry, loader state enum and header field layout
package fabric_pkg;

    localparam int FABRIC_ROWS             = 2;
    localparam int FABRIC_COLS             = 2;
    localparam int FABRIC_INSTR_DATA_WIDTH = 32;
    localparam int FABRIC_INSTR_ADDR_WIDTH = 6;
    localparam int FABRIC_INSTR_HOPS_WIDTH = 4;

    localparam int HDR_ROW_LSB = 0;
    localparam int HDR_COL_LSB = 16;
    localparam int HDR_FIELD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALL,
        SETTLE,
        WAIT_RET,
        DONE
    } loader_state_t;

    function automatic logic [HDR_FIELD_W-1:0] hdr_row(input logic [31:0] word);
        return word[HDR_ROW_LSB +: HDR_FIELD_W];
    endfunction

    function automatic logic [HDR_FIELD_W-1:0] hdr_col(input logic [31:0] word);
        return word[HDR_COL_LSB +: HDR_FIELD_W];
    endfunction

endpackage

// File: rtl/fabric_program_loader_if.sv
// rtl/fabric_program_loader_if.sv - program-beat stream between a beat source and the loader
interface fabric_program_loader_if #(
    parameter int DATA_W = 32
) ();

    logic              s_valid;
    logic              s_ready;
    logic              s_is_header;
    logic              s_last;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_is_header,
        output s_last,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_is_header,
        input  s_last,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/fabric_program_writer.sv
// rtl/fabric_program_writer.sv - per-cell index/validity tracking and registered row demux onto instr_*
module fabric_program_writer
    import fabric_pkg::*;
#(
    parameter int ROWS             = FABRIC_ROWS,
    parameter int COLS             = FABRIC_COLS,
    parameter int INSTR_DATA_WIDTH = FABRIC_INSTR_DATA_WIDTH,
    parameter int INSTR_ADDR_WIDTH = FABRIC_INSTR_ADDR_WIDTH,
    parameter int INSTR_HOPS_WIDTH = FABRIC_INSTR_HOPS_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clear_i,
    input  logic                                 beat_valid_i,
    input  logic                                 beat_is_header_i,
    input  logic [INSTR_DATA_WIDTH-1:0]          beat_data_i,
    output logic [ROWS*INSTR_DATA_WIDTH-1:0]     instr_data_o,
    output logic [ROWS*INSTR_ADDR_WIDTH-1:0]     instr_addr_o,
    output logic [ROWS*INSTR_HOPS_WIDTH-1:0]     instr_hops_o,
    output logic [ROWS-1:0]                      instr_en_o,
    output logic                                 err_o
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ROW_W-1:0]                  row_q;
    logic [INSTR_HOPS_WIDTH-1:0]       col_q;
    logic [INSTR_ADDR_WIDTH-1:0]       idx_q;
    logic                              have_hdr_q;
    logic                              cell_ok_q;
    logic                              ovf_q;
    logic [ROWS-1:0]                   en_q;
    logic [ROWS*INSTR_DATA_WIDTH-1:0]  data_q;
    logic [ROWS*INSTR_ADDR_WIDTH-1:0]  addr_q;
    logic [ROWS*INSTR_HOPS_WIDTH-1:0]  hops_q;

    logic [HDR_FIELD_W-1:0] hdr_row_w;
    logic [HDR_FIELD_W-1:0] hdr_col_w;
    logic                   hdr_ok;
    logic                   is_hdr;
    logic                   is_ins;
    logic                   wr_ok;
    logic [ROWS-1:0]        lane_wr;

    assign hdr_row_w = hdr_row(beat_data_i[31:0]);
    assign hdr_col_w = hdr_col(beat_data_i[31:0]);
    assign hdr_ok    = ({16'd0, hdr_row_w} < 32'(ROWS)) && ({16'd0, hdr_col_w} < 32'(COLS));
    assign is_hdr    = beat_valid_i & beat_is_header_i;
    assign is_ins    = beat_valid_i & ~beat_is_header_i;
    // Overflow is sticky until the next header so a wrapped index never rewrites address 0.
    assign wr_ok     = is_ins & have_hdr_q & cell_ok_q & ~ovf_q;
    assign err_o     = (is_hdr & ~hdr_ok) | (is_ins & ~wr_ok);

    always_comb begin
        lane_wr = '0;
        for (int r = 0; r < ROWS; r++) begin
            lane_wr[r] = wr_ok && (row_q == ROW_W'(r));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q      <= '0;
            col_q      <= '0;
            idx_q      <= '0;
            have_hdr_q <= 1'b0;
            cell_ok_q  <= 1'b0;
            ovf_q      <= 1'b0;
            en_q       <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            hops_q     <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                en_q[r]                                       <= lane_wr[r];
                data_q[r*INSTR_DATA_WIDTH +: INSTR_DATA_WIDTH] <= lane_wr[r] ? beat_data_i : '0;
                addr_q[r*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH] <= lane_wr[r] ? idx_q : '0;
                hops_q[r*INSTR_HOPS_WIDTH +: INSTR_HOPS_WIDTH] <= lane_wr[r] ? col_q : '0;
            end
            if (clear_i) begin
                row_q      <= '0;
                col_q      <= '0;
                idx_q      <= '0;
                have_hdr_q <= 1'b0;
                cell_ok_q  <= 1'b0;
                ovf_q      <= 1'b0;
            end else if (is_hdr) begin
                row_q      <= hdr_row_w[ROW_W-1:0];
                col_q      <= hdr_col_w[INSTR_HOPS_WIDTH-1:0];
                idx_q      <= '0;
                have_hdr_q <= 1'b1;
                cell_ok_q  <= hdr_ok;
                ovf_q      <= 1'b0;
            end else if (wr_ok) begin
                idx_q <= idx_q + INSTR_ADDR_WIDTH'(1);
                if (&idx_q) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign instr_en_o   = en_q;
    assign instr_data_o = data_q;
    assign instr_addr_o = addr_q;
    assign instr_hops_o = hops_q;

endmodule

// File: rtl/fabric_program_loader.sv
// rtl/fabric_program_loader.sv - load/call/wait sequencer upstream of fabric
// Optional watchdog in WAIT_RET enabled by FABRIC_PROGRAM_LOADER_TIMEOUT_EN.
module fabric_program_loader
    import fabric_pkg::*;
#(
    parameter int ROWS             = FABRIC_ROWS,
    parameter int COLS             = FABRIC_COLS,
    parameter int INSTR_DATA_WIDTH = FABRIC_INSTR_DATA_WIDTH,
    parameter int INSTR_ADDR_WIDTH = FABRIC_INSTR_ADDR_WIDTH,
    parameter int INSTR_HOPS_WIDTH = FABRIC_INSTR_HOPS_WIDTH,
    parameter int CYCLE_CNT_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES   = 1000000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    fabric_program_loader_if.slave              beat,
    output logic [ROWS*INSTR_DATA_WIDTH-1:0]    instr_data_out,
    output logic [ROWS*INSTR_ADDR_WIDTH-1:0]    instr_addr_out,
    output logic [ROWS*INSTR_HOPS_WIDTH-1:0]    instr_hops_out,
    output logic [ROWS-1:0]                     instr_en_out,
    output logic [ROWS-1:0]                     call,
    input  logic [ROWS-1:0]                     ret,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic                                timeout,
    output logic [CYCLE_CNT_WIDTH-1:0]          cycles
);

    localparam int SETTLE_CYCLES = 2 * COLS;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

    loader_state_t              state_q;
    logic [ROWS-1:0]            call_q;
    logic                       done_q;
    logic                       error_q;
    logic [CYCLE_CNT_WIDTH-1:0] cycles_q;
    logic [CYCLE_CNT_WIDTH-1:0] cycles_d;
    logic [SETTLE_W-1:0]        settle_q;
    logic                       beat_accept;
    logic                       wr_err;
    logic                       clear;

`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign beat.s_ready = (state_q == LOAD);
    assign beat_accept  = beat.s_valid & beat.s_ready;
    assign clear        = start & (state_q == IDLE);
    assign cycles_d     = (&cycles_q) ? cycles_q : cycles_q + CYCLE_CNT_WIDTH'(1);

    fabric_program_writer #(
        .ROWS             (ROWS),
        .COLS             (COLS),
        .INSTR_DATA_WIDTH (INSTR_DATA_WIDTH),
        .INSTR_ADDR_WIDTH (INSTR_ADDR_WIDTH),
        .INSTR_HOPS_WIDTH (INSTR_HOPS_WIDTH)
    ) u_writer (
        .clk_i            (clk),
        .rst_i            (rst),
        .clear_i          (clear),
        .beat_valid_i     (beat_accept),
        .beat_is_header_i (beat.s_is_header),
        .beat_data_i      (beat.s_data),
        .instr_data_o     (instr_data_out),
        .instr_addr_o     (instr_addr_out),
        .instr_hops_o     (instr_hops_out),
        .instr_en_o       (instr_en_out),
        .err_o            (wr_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            call_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cycles_q <= '0;
            settle_q <= '0;
`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            call_q <= '0;
            done_q <= 1'b0;
            if (wr_err) begin
                error_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        error_q  <= 1'b0;
                        cycles_q <= '0;
`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    // The last beat's own write lands in the same cycle as call.
                    if (beat_accept && beat.s_last) begin
                        state_q <= CALL;
                        call_q  <= '1;
                    end
                end
                CALL: begin
                    cycles_q <= cycles_d;
                    settle_q <= '0;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    // ret from the previous run may still be high; ignore it here.
                    cycles_q <= cycles_d;
                    if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= WAIT_RET;
`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
                        wd_q <= '0;
`endif
                    end else begin
                        settle_q <= settle_q + SETTLE_W'(1);
                    end
                end
                WAIT_RET: begin
                    cycles_q <= cycles_d;
                    if (&ret) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign call   = call_q;
    assign done   = done_q;
    assign error  = error_q;
    assign busy   = (state_q != IDLE);
    assign cycles = cycles_q;
`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_program_loader.sv
// tb/tb_fabric_program_loader.sv - directed bench with a write-list model for fabric_program_loader
module tb_fabric_program_loader;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int HW    = 4;
    localparam int CW    = 32;
    localparam int TO    = 50;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [ROWS-1:0]      ret = '0;
    logic [ROWS*DW-1:0]   instr_data_out;
    logic [ROWS*AW-1:0]   instr_addr_out;
    logic [ROWS*HW-1:0]   instr_hops_out;
    logic [ROWS-1:0]      instr_en_out;
    logic [ROWS-1:0]      call;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic                 timeout;
    logic [CW-1:0]        cycles;

    fabric_program_loader_if #(.DATA_W(DW)) beat_if ();

    fabric_program_loader #(
        .ROWS (ROWS), .COLS (COLS), .INSTR_DATA_WIDTH (DW), .INSTR_ADDR_WIDTH (AW),
        .INSTR_HOPS_WIDTH (HW), .CYCLE_CNT_WIDTH (CW), .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .beat (beat_if),
        .instr_data_out (instr_data_out), .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out), .instr_en_out (instr_en_out),
        .call (call), .ret (ret), .busy (busy), .done (done), .error (error),
        .timeout (timeout), .cycles (cycles)
    );

    always #5 clk = ~clk;

    typedef struct { bit hdr; bit last; logic [31:0] data; } beat_t;
    typedef struct { int row; int addr; int hops; logic [31:0] data; } wr_t;

    beat_t prog[$];
    wr_t   exp_q[$];
    bit    exp_err;
    int    exp_last_row;
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_hdr(input int r, input int c);
        beat_t b;
        b.hdr = 1'b1; b.last = 1'b0; b.data = {c[15:0], r[15:0]};
        prog.push_back(b);
    endfunction

    function automatic void add_ins(input logic [31:0] d);
        beat_t b;
        b.hdr = 1'b0; b.last = 1'b0; b.data = d;
        prog.push_back(b);
    endfunction

    // Expected writes straight from the program rules: one entry per instruction that lands.
    function automatic void model_build();
        bit have = 1'b0;
        int r = 0, c = 0, idx = 0;
        wr_t w;
        exp_q.delete();
        exp_err = 1'b0;
        exp_last_row = -1;
        foreach (prog[i]) begin
            exp_last_row = -1;
            if (prog[i].hdr) begin
                r = int'(prog[i].data[15:0]);
                c = int'(prog[i].data[31:16]);
                idx = 0;
                have = 1'b1;
                if (r >= ROWS || c >= COLS) exp_err = 1'b1;
            end else if (!have || r >= ROWS || c >= COLS || idx >= DEPTH) begin
                exp_err = 1'b1;
            end else begin
                w.row = r; w.addr = idx; w.hops = c; w.data = prog[i].data;
                exp_q.push_back(w);
                exp_last_row = r;
                idx++;
            end
        end
    endfunction

    function automatic bit ret_high(input int k, input int ret_at, input bit stale);
        return (stale && k >= 1 && k <= 2 * COLS) || (k >= ret_at);
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (mon_on) begin
            chk("en_one_hot", 64'($countones(instr_en_out) <= 1), 64'd1);
            for (int r = 0; r < ROWS; r++) begin
                if (instr_en_out[r]) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: lane %0d data 0x%0h, expected no write", r, instr_data_out[r*DW +: DW]);
                    end else begin
                        w = exp_q.pop_front();
                        chk("write_row", 64'(r), 64'(w.row));
                        chk("write_addr", 64'(instr_addr_out[r*AW +: AW]), 64'(w.addr));
                        chk("write_hops", 64'(instr_hops_out[r*HW +: HW]), 64'(w.hops));
                        chk("write_data", 64'(instr_data_out[r*DW +: DW]), 64'(w.data));
                    end
                end else begin
                    chk("idle_lane_zero", 64'({instr_data_out[r*DW +: DW], instr_addr_out[r*AW +: AW], instr_hops_out[r*HW +: HW]}), 64'd0);
                end
            end
        end
    end

    task automatic drive_beat(input int i);
        beat_if.s_valid     = 1'b1;
        beat_if.s_is_header = prog[i].hdr;
        beat_if.s_last      = prog[i].last;
        beat_if.s_data      = prog[i].data;
    endtask

    task automatic idle_beat();
        beat_if.s_valid = 1'b0; beat_if.s_is_header = 1'b0;
        beat_if.s_last  = 1'b0; beat_if.s_data = '0;
    endtask

    task automatic load_only();
        prog[prog.size()-1].last = 1'b1;
        model_build();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("s_ready_in_load", 64'(beat_if.s_ready), 64'd1);
        chk("error_cleared", 64'(error), 64'd0);
        chk("cycles_cleared", 64'(cycles), 64'd0);
        foreach (prog[i]) begin
            drive_beat(i);
            tick();
        end
        idle_beat();
        chk("call_entry", 64'(call), 64'(2'b11));
        chk("final_write_with_call", 64'(instr_en_out), (exp_last_row >= 0) ? (64'd1 << exp_last_row) : 64'd0);
    endtask

    task automatic run(input int ret_at, input bit stale, output logic [31:0] cyc_seen);
        int kd = 0;
        for (int k = 1 + 2 * COLS; k < 1000 && kd == 0; k++) begin
            if (ret_high(k, ret_at, stale)) kd = k + 1;
        end
        load_only();
        ret = ret_high(0, ret_at, stale) ? '1 : '0;
        cyc_seen = '0;
        for (int k = 1; k <= kd; k++) begin
            tick();
            chk("call_one_cycle", 64'(call), 64'd0);
            chk("done_timing", 64'(done), 64'(k == kd));
            if (k == kd) begin
                cyc_seen = cycles;
                chk("cycles_count", 64'(cycles), 64'(kd));
                chk("error_flag", 64'(error), 64'(exp_err));
            end
            ret = ret_high(k, ret_at, stale) ? '1 : '0;
        end
        ret = '0;
        tick();
        chk("done_single", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_limit: simulation still running, expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] cyc;
        wr_t w;
        idle_beat();
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outputs", 64'({call, done, busy, error, timeout, instr_en_out, beat_if.s_ready}), 64'd0);
        chk("reset_cycles", 64'(cycles), 64'd0);
        chk("reset_bus", 64'({instr_data_out[31:0], instr_addr_out, instr_hops_out}), 64'd0);
        mon_on = 1'b1;

        // Single cell, ret stale through SETTLE then raised ten cycles after call.
        prog.delete(); add_hdr(1, 0); add_ins(32'hA); add_ins(32'hB); add_ins(32'hC);
        prog[prog.size()-1].last = 1'b1;
        model_build();
        chk("model_t1_count", 64'(exp_q.size()), 64'd3);
        chk("model_t1_first", 64'({exp_q[0].row[7:0], exp_q[0].addr[7:0], exp_q[0].hops[7:0], exp_q[0].data}), 64'h01_00_00_0000000A);
        chk("model_t1_last", 64'({exp_q[2].row[7:0], exp_q[2].addr[7:0], exp_q[2].hops[7:0], exp_q[2].data}), 64'h01_02_00_0000000C);
        run(10, 1'b1, cyc);
        chk("t1_cycles_literal", 64'(cyc), 64'd11);
        chk("t1_error_literal", 64'(error), 64'd0);

        // Two cells in column 1.
        prog.delete(); add_hdr(0, 1); add_ins(32'h11); add_ins(32'h12); add_hdr(1, 1); add_ins(32'h21);
        prog[prog.size()-1].last = 1'b1;
        model_build();
        chk("model_t2_second_cell", 64'({exp_q[2].row[7:0], exp_q[2].addr[7:0], exp_q[2].hops[7:0], exp_q[2].data}), 64'h01_00_01_00000021);
        run(3, 1'b0, cyc);
        chk("t2_cycles_literal", 64'(cyc), 64'd6);
        chk("t2_error_literal", 64'(error), 64'd0);

        // Instruction before any header.
        prog.delete(); add_ins(32'hDEAD); add_hdr(0, 0); add_ins(32'h1);
        run(7, 1'b0, cyc);
        chk("t3_error_literal", 64'(error), 64'd1);
        chk("t3_cycles_literal", 64'(cyc), 64'd8);

        // Header with out-of-range row.
        prog.delete(); add_hdr(5, 0); add_ins(32'h2); add_ins(32'h3); add_hdr(1, 1); add_ins(32'h4);
        run(5, 1'b0, cyc);
        chk("t4_error_literal", 64'(error), 64'd1);

        // 65 instructions into one cell; the 65th must drop.
        prog.delete(); add_hdr(0, 1);
        for (int i = 0; i < 65; i++) add_ins(32'h100 + 32'(i));
        add_hdr(1, 0); add_ins(32'h77);
        prog[prog.size()-1].last = 1'b1;
        model_build();
        chk("model_t5_count", 64'(exp_q.size()), 64'd65);
        run(5, 1'b0, cyc);
        chk("t5_error_literal", 64'(error), 64'd1);

        // Reset in LOAD together with a third beat.
        prog.delete(); add_hdr(1, 0); add_ins(32'h5); add_ins(32'h6);
        exp_q.delete();
        w.row = 1; w.addr = 0; w.hops = 0; w.data = 32'h5;
        exp_q.push_back(w);
        start = 1'b1; tick(); start = 1'b0;
        drive_beat(0); tick();
        drive_beat(1); tick();
        chk("rst_pre_write", 64'(instr_en_out), 64'(2'b10));
        drive_beat(2); rst = 1'b1; tick(); rst = 1'b0; idle_beat();
        chk("rst_mid_outputs", 64'({call, done, busy, error, timeout, instr_en_out, beat_if.s_ready}), 64'd0);
        chk("rst_mid_bus", 64'({instr_data_out[63:32], instr_addr_out, instr_hops_out}), 64'd0);
        tick();
        chk("rst_pending_cancelled", 64'(instr_en_out), 64'd0);
        chk("rst_writes_seen", 64'(exp_q.size()), 64'd0);

        prog.delete(); add_hdr(1, 0); add_ins(32'hA); add_ins(32'hB); add_ins(32'hC);
        run(4, 1'b0, cyc);
        chk("reload_cycles_literal", 64'(cyc), 64'd6);

        // ret never rises.
        prog.delete(); add_hdr(0, 0); add_ins(32'h9);
        load_only();
        ret = '0;
`ifdef FABRIC_PROGRAM_LOADER_TIMEOUT_EN
        for (int k = 1; k <= 1 + 2 * COLS + TO; k++) begin
            tick();
            chk("wd_done_timing", 64'(done), 64'(k == 1 + 2 * COLS + TO));
            if (k == 1 + 2 * COLS + TO) begin
                chk("wd_timeout", 64'(timeout), 64'd1);
                chk("wd_cycles", 64'(cycles), 64'd55);
            end
        end
        tick();
        chk("wd_busy_idle", 64'(busy), 64'd0);
`else
        repeat (200) tick();
        chk("no_wd_busy", 64'(busy), 64'd1);
        chk("no_wd_timeout", 64'(timeout), 64'd0);
        chk("no_wd_done", 64'(done), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("no_wd_reset_busy", 64'(busy), 64'd0);
`endif
        chk("t8_writes_seen", 64'(exp_q.size()), 64'd0);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
